// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Shares the reg_bank access port between two requesters (0 = SPI,
//   1 = I2C). Each requester holds req high and receives a one-cycle ack.
//   One bank access is issued per grant. A tie goes to the requester that
//   did not win last time. A WAIT that never sees bank_ack is aborted with
//   err=1 after TIMEOUT cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ena                 enables new grants; an in-flight access always completes
//   mN_req/wr_rdn/addr/wdata   requester N command (held stable while req is high)
//   mN_ack/rdata/err    requester N completion pulse, read data, error
//   bank_valid/we/wr_rdn/addr/wdata   registered command toward reg_bank
//   bank_rdata/ack/err  reg_bank response
//   busy, grant         status: not IDLE, one-hot owner of the current access
module reg_bus_arbiter #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  m0_req,
    input  logic                  m0_wr_rdn,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [REG_WIDTH-1:0]  m0_wdata,
    output logic                  m0_ack,
    output logic [REG_WIDTH-1:0]  m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_wr_rdn,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [REG_WIDTH-1:0]  m1_wdata,
    output logic                  m1_ack,
    output logic [REG_WIDTH-1:0]  m1_rdata,
    output logic                  m1_err,
    output logic                  bank_valid,
    output logic                  bank_we,
    output logic                  bank_wr_rdn,
    output logic [ADDR_WIDTH-1:0] bank_addr,
    output logic [REG_WIDTH-1:0]  bank_wdata,
    input  logic [REG_WIDTH-1:0]  bank_rdata,
    input  logic                  bank_ack,
    input  logic                  bank_err,
    output logic                  busy,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    // Requester-indexed views of the two command ports.
    logic                  w_req    [2];
    logic                  w_wr_rdn [2];
    logic [ADDR_WIDTH-1:0] w_addr   [2];
    logic [REG_WIDTH-1:0]  w_wdata  [2];

    assign w_req[0]    = m0_req;
    assign w_req[1]    = m1_req;
    assign w_wr_rdn[0] = m0_wr_rdn;
    assign w_wr_rdn[1] = m1_wr_rdn;
    assign w_addr[0]   = m0_addr;
    assign w_addr[1]   = m1_addr;
    assign w_wdata[0]  = m0_wdata;
    assign w_wdata[1]  = m1_wdata;

    state_t                r_state, r_state_next;
    logic                  r_last_grant, r_last_grant_next;
    logic [1:0]            r_grant, r_grant_next;
    logic                  r_busy, r_busy_next;
    logic [7:0]            r_cnt, r_cnt_next;
    logic                  r_bank_valid, r_bank_valid_next;
    logic                  r_bank_we, r_bank_we_next;
    logic                  r_bank_wr_rdn, r_bank_wr_rdn_next;
    logic [ADDR_WIDTH-1:0] r_bank_addr, r_bank_addr_next;
    logic [REG_WIDTH-1:0]  r_bank_wdata, r_bank_wdata_next;
    logic [1:0]            r_ack, r_ack_next;
    logic [1:0]            r_err, r_err_next;
    logic [REG_WIDTH-1:0]  r_rdata [2];
    logic [REG_WIDTH-1:0]  r_rdata_next [2];

    logic w_win;    // requester chosen in IDLE
    logic w_owner;  // requester that owns the current access

    assign w_owner = r_grant[1];

    always_comb begin
        r_state_next       = r_state;
        r_last_grant_next  = r_last_grant;
        r_grant_next       = r_grant;
        r_cnt_next         = r_cnt;
        r_bank_valid_next  = 1'b0;
        r_bank_we_next     = 1'b0;
        r_bank_wr_rdn_next = r_bank_wr_rdn;
        r_bank_addr_next   = r_bank_addr;
        r_bank_wdata_next  = r_bank_wdata;
        r_ack_next         = 2'b00;
        r_err_next         = r_err;
        r_rdata_next       = r_rdata;
        w_win              = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (ena && (w_req[0] || w_req[1])) begin
                    // Tie goes to the requester that was not served last;
                    // a lone request wins outright.
                    if (w_req[0] && w_req[1]) begin
                        w_win = ~r_last_grant;
                    end else begin
                        w_win = w_req[1];
                    end
                    r_grant_next       = w_win ? 2'b10 : 2'b01;
                    r_bank_wr_rdn_next = w_wr_rdn[w_win];
                    r_bank_addr_next   = w_addr[w_win];
                    r_bank_wdata_next  = w_wdata[w_win];
                    // Strobe is registered here so it is high during ISSUE.
                    r_bank_valid_next  = 1'b1;
                    r_bank_we_next     = w_wr_rdn[w_win];
                    r_state_next       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                r_cnt_next   = 8'd0;
                r_state_next = S_WAIT;
            end
            S_WAIT: begin
                // bank_ack has priority over a timeout in the same cycle.
                if (bank_ack) begin
                    r_rdata_next[w_owner] = bank_rdata;
                    r_err_next[w_owner]   = bank_err;
                    r_ack_next[w_owner]   = 1'b1;
                    r_state_next          = S_RESP;
                end else if (r_cnt + 8'd1 == TIMEOUT_L) begin
                    r_rdata_next[w_owner] = '0;
                    r_err_next[w_owner]   = 1'b1;
                    r_ack_next[w_owner]   = 1'b1;
                    r_state_next          = S_RESP;
                end else begin
                    r_cnt_next = r_cnt + 8'd1;
                end
            end
            S_RESP: begin
                // ack/rdata/err are visible during RESP and cleared on exit.
                r_rdata_next[0]   = '0;
                r_rdata_next[1]   = '0;
                r_err_next        = 2'b00;
                r_last_grant_next = w_owner;
                r_grant_next      = 2'b00;
                r_state_next      = S_IDLE;
            end
            default: begin
                r_state_next = S_IDLE;
                r_grant_next = 2'b00;
            end
        endcase

        r_busy_next = (r_state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_grant       <= 2'b00;
            r_busy        <= 1'b0;
            r_cnt         <= 8'd0;
            r_bank_valid  <= 1'b0;
            r_bank_we     <= 1'b0;
            r_bank_wr_rdn <= 1'b0;
            r_bank_addr   <= '0;
            r_bank_wdata  <= '0;
            r_ack         <= 2'b00;
            r_err         <= 2'b00;
            r_rdata[0]    <= '0;
            r_rdata[1]    <= '0;
        end else begin
            r_state       <= r_state_next;
            r_last_grant  <= r_last_grant_next;
            r_grant       <= r_grant_next;
            r_busy        <= r_busy_next;
            r_cnt         <= r_cnt_next;
            r_bank_valid  <= r_bank_valid_next;
            r_bank_we     <= r_bank_we_next;
            r_bank_wr_rdn <= r_bank_wr_rdn_next;
            r_bank_addr   <= r_bank_addr_next;
            r_bank_wdata  <= r_bank_wdata_next;
            r_ack         <= r_ack_next;
            r_err         <= r_err_next;
            r_rdata[0]    <= r_rdata_next[0];
            r_rdata[1]    <= r_rdata_next[1];
        end
    end

    assign m0_ack      = r_ack[0];
    assign m1_ack      = r_ack[1];
    assign m0_err      = r_err[0];
    assign m1_err      = r_err[1];
    assign m0_rdata    = r_rdata[0];
    assign m1_rdata    = r_rdata[1];
    assign bank_valid  = r_bank_valid;
    assign bank_we     = r_bank_we;
    assign bank_wr_rdn = r_bank_wr_rdn;
    assign bank_addr   = r_bank_addr;
    assign bank_wdata  = r_bank_wdata;
    assign busy        = r_busy;
    assign grant       = r_grant;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter
//   Directed vectors for reg_bus_arbiter: a table of single transactions
//   (request pattern, bank response, expected bank command and completion)
//   followed by hand-written ena-gating and reset-during-WAIT sequences.
module tb_reg_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       m0_req, m0_wr_rdn, m1_req, m1_wr_rdn;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] m0_rdata, m1_rdata;
    logic       bank_valid, bank_we, bank_wr_rdn;
    logic [7:0] bank_addr, bank_wdata, bank_rdata;
    logic       bank_ack, bank_err;
    logic       busy;
    logic [1:0] grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.REG_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .m0_req(m0_req), .m0_wr_rdn(m0_wr_rdn), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr_rdn(m1_wr_rdn), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bank_valid(bank_valid), .bank_we(bank_we), .bank_wr_rdn(bank_wr_rdn),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .bank_ack(bank_ack), .bank_err(bank_err), .busy(busy), .grant(grant)
    );

    typedef struct {
        logic       r0, r1, w0, w1;
        logic [7:0] a0, a1, d0, d1;
        int         dly;        // cycles from bank_valid to bank_ack; 0 = never
        logic [7:0] brd;
        logic       berr;
        logic [1:0] xg;
        logic       xwe;
        logic [7:0] xaddr, xwd, xrd;
        logic       xerr;
        int         xlat;       // negedges from bank_valid to ack
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {bank_valid, bank_we, bank_wr_rdn, bank_addr, bank_wdata, busy, grant,
                m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata};
    endfunction

    // Called at a negedge with the arbiter in IDLE; returns at a negedge in IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        int  c;
        bit  seen;
        logic [7:0] own_rd, oth_rd;
        m0_req = v.r0; m0_wr_rdn = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_wr_rdn = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
        bank_rdata = v.brd; bank_err = v.berr; bank_ack = 1'b0;
        @(negedge clk);
        chk("issue_valid", bank_valid, 1'b1);
        chk("issue_grant", grant, v.xg);
        chk("issue_we", bank_we, v.xwe);
        chk("issue_addr", bank_addr, v.xaddr);
        chk("issue_wdata", bank_wdata, v.xwd);
        chk("issue_busy", busy, 1'b1);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            bank_ack = (v.dly != 0 && c == v.dly);
            @(negedge clk);
            c++;
            if (c == 1) begin
                chk("valid_one_cycle", {bank_valid, bank_we}, 2'b00);
            end
            if (m0_ack || m1_ack) seen = 1'b1;
        end
        bank_ack = 1'b0;
        if (!seen) begin
            chk("ack_never_seen", 1'b0, 1'b1);
        end else begin
            own_rd = v.xg[1] ? m1_rdata : m0_rdata;
            oth_rd = v.xg[1] ? m0_rdata : m1_rdata;
            chk("ack_latency", c, v.xlat);
            chk("ack_owner", {m1_ack, m0_ack}, v.xg);
            chk("resp_rdata", own_rd, v.xrd);
            chk("resp_err", v.xg[1] ? m1_err : m0_err, v.xerr);
            chk("other_port_quiet", {oth_rd, v.xg[1] ? m0_err : m1_err}, 9'd0);
            $display("txn %0d: grant=%b rdata=%h err=%b latency=%0d",
                     idx, {m1_ack, m0_ack}, own_rd, v.xg[1] ? m1_err : m0_err, c);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk("after_resp_idle", {busy, grant, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          r0 r1 w0 w1 a0     a1     d0     d1     dly brd    berr xg     xwe xaddr  xwd    xrd    xerr lat
        vecs[0] = '{1, 0, 1, 0, 8'h03, 8'h00, 8'hA5, 8'h00, 1,  8'h11, 0,   2'b01, 1,  8'h03, 8'hA5, 8'h11, 0,   2};
        vecs[1] = '{0, 1, 0, 0, 8'h00, 8'h09, 8'h00, 8'h00, 1,  8'h5C, 0,   2'b10, 0,  8'h09, 8'h00, 8'h5C, 0,   2};
        vecs[2] = '{1, 1, 1, 0, 8'h10, 8'h20, 8'h01, 8'hBB, 1,  8'h22, 0,   2'b01, 1,  8'h10, 8'h01, 8'h22, 0,   2};
        vecs[3] = '{1, 1, 1, 0, 8'h10, 8'h20, 8'h01, 8'hBB, 3,  8'h77, 1,   2'b10, 0,  8'h20, 8'hBB, 8'h77, 1,   4};
        vecs[4] = '{1, 1, 1, 0, 8'h10, 8'h20, 8'h01, 8'hBB, 2,  8'h33, 0,   2'b01, 1,  8'h10, 8'h01, 8'h33, 0,   3};
        vecs[5] = '{1, 1, 1, 0, 8'h10, 8'h20, 8'h01, 8'hBB, 1,  8'h44, 0,   2'b10, 0,  8'h20, 8'hBB, 8'h44, 0,   2};
        vecs[6] = '{1, 0, 0, 0, 8'h5E, 8'h00, 8'h00, 8'h00, 0,  8'hEE, 0,   2'b01, 0,  8'h5E, 8'h00, 8'h00, 1,   16};
        vecs[7] = '{0, 1, 0, 0, 8'h00, 8'h6F, 8'h00, 8'h00, 15, 8'hC3, 0,   2'b10, 0,  8'h6F, 8'h00, 8'hC3, 0,   16};
        vecs[8] = '{0, 1, 0, 1, 8'h00, 8'h7A, 8'h00, 8'h3C, 1,  8'h01, 0,   2'b10, 1,  8'h7A, 8'h3C, 8'h01, 0,   2};

        rst = 1'b1; ena = 1'b1;
        m0_req = 0; m0_wr_rdn = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr_rdn = 0; m1_addr = 0; m1_wdata = 0;
        bank_rdata = 0; bank_ack = 0; bank_err = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // ena gating: m0 waits while ena=0, then is granted on the next edge.
        ena = 1'b0;
        m0_req = 1; m0_wr_rdn = 1; m0_addr = 8'h44; m0_wdata = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("ena_low_no_grant", {bank_valid, busy}, 2'b00);
        end
        ena = 1'b1;
        @(negedge clk);
        chk("ena_grant_valid", {bank_valid, bank_we, grant}, 4'b1101);
        ena = 1'b0;                   // dropped before WAIT; access must finish
        @(negedge clk);
        bank_ack = 1'b1; bank_rdata = 8'h66; bank_err = 1'b0;
        @(negedge clk);
        bank_ack = 1'b0;
        chk("ena_drop_ack", {m0_ack, m0_rdata, m0_err}, {1'b1, 8'h66, 1'b0});
        $display("txn ena: grant=01 rdata=%h err=%b", m0_rdata, m0_err);
        m0_req = 1'b0; ena = 1'b1;
        @(negedge clk);

        // Reset in WAIT: m1 is in flight and last winner was m0.
        m1_req = 1; m1_wr_rdn = 0; m1_addr = 8'h77;
        @(negedge clk);
        chk("rst_seq_grant", grant, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_outputs", all_outs(), 64'd0);
        rst = 1'b0; m1_req = 1'b0;
        bank_ack = 1'b1; bank_rdata = 8'h99;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_late_ack", {m0_ack, m1_ack, busy}, 3'b000);
        end
        bank_ack = 1'b0;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("rst_tie_goes_m0", grant, 2'b01);
        $display("txn rst: tie after reset grant=%b", grant);
        m0_req = 0; m1_req = 0;
        bank_ack = 1'b1; bank_rdata = 8'h12;
        @(negedge clk);
        @(negedge clk);
        bank_ack = 1'b0;
        chk("rst_tie_ack", {m0_ack, m1_ack, m0_rdata}, {2'b10, 8'h12});
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
